ram_burst_master: RTL and testbench

//  Initiator for the single-port RAM interface (en / wr_rdn / addr / data_wr / data_rd, 1-cycle read latency).

---
 rtl/ram_if_pkg.sv | 6 +
 rtl/rd_skid_fifo.sv | 30 +++
 rtl/ram_burst_master.sv | 92 +++++++++
 tb/tb_ram_burst_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_if_pkg.sv
// ram_if_pkg: shared state type and default widths for the RAM burst master.
package ram_if_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  typedef enum logic [1:0] {IDLE, WRITE, READ} ram_burst_state_t;
endpackage

// File: rtl/rd_skid_fifo.sv
// rd_skid_fifo: 2-entry {last, data} FIFO with occupancy count; push and pop may share a cycle.
module rd_skid_fifo #(
  parameter int DW = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        push,
  input  logic [DW:0] din,
  input  logic        pop,
  output logic [DW:0] dout,
  output logic [1:0]  count
);
  logic [DW:0] mem [2];
  logic wp, rp;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= '0;
    end else begin
      if (push) mem[wp] <= din;
      wp <= wp ^ push;
      rp <= rp ^ pop;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  assign dout = mem[rp];
endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master: runs one wrapping-address burst at a time over a 1-cycle-latency single-port RAM.
module ram_burst_master
  import ram_if_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic                  ram_wr_rdn,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_wr,
  input  logic [DATA_WIDTH-1:0] ram_data_rd
);
  ram_burst_state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cur_addr, cnt;
  logic remain, inflight, inflight_last;
  logic wr_hs, issue, pop;
  logic [1:0] fifo_count;
  logic [2:0] occ;
  logic [DATA_WIDTH:0] fifo_dout;
  assign wr_hs = state == WRITE && wdata_valid;
  assign pop = rdata_valid && rdata_ready;
  // Slots already claimed in the 2-deep FIFO, counting the read still in the RAM pipe.
  assign occ = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
  assign issue = state == READ && remain && occ <= 3'd1;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = (state == IDLE && cmd_valid) ? (cmd_wr ? WRITE : READ) :
               ((wr_hs && cnt == '0) || (pop && rdata_last)) ? IDLE : state;
    cmd_ready = state == IDLE;
    busy = state != IDLE;
    wdata_ready = state == WRITE;
    ram_en = wr_hs || issue;
    ram_wr_rdn = wr_hs;
    ram_addr = ram_en ? cur_addr : '0;
    ram_data_wr = wr_hs ? wdata : '0;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_addr <= '0;
      cnt <= '0;
      remain <= 1'b0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state != IDLE && state_nx == IDLE;
      inflight <= issue;
      inflight_last <= issue && cnt == '0;
      if (cmd_valid && cmd_ready) begin
        cur_addr <= cmd_addr;
        cnt <= cmd_len;
        remain <= !cmd_wr;
      end else if (wr_hs || issue) begin
        cur_addr <= cur_addr + 1'b1;
        cnt <= cnt - 1'b1;
        if (issue && cnt == '0) remain <= 1'b0;
      end
    end
  end
  rd_skid_fifo #(.DW(DATA_WIDTH)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .push(inflight),
    .din({inflight_last, ram_data_rd}),
    .pop(pop),
    .dout(fifo_dout),
    .count(fifo_count)
  );
  assign rdata_valid = fifo_count != '0;
  assign rdata = fifo_dout[DATA_WIDTH-1:0];
  assign rdata_last = rdata_valid && fifo_dout[DATA_WIDTH];
endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: randomized bursts against a RAM model, checked by a queue-based scoreboard.
module tb_ram_burst_master;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int N = 1 << AW;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
  logic wdata_valid = 1'b0, wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic rdata_valid, rdata_ready, rdata_last, busy, done;
  logic [DW-1:0] rdata;
  logic ram_en, ram_wr_rdn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_wr, ram_data_rd;
  ram_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .rdata_last(rdata_last),
    .busy(busy), .done(done),
    .ram_en(ram_en), .ram_wr_rdn(ram_wr_rdn), .ram_addr(ram_addr),
    .ram_data_wr(ram_data_wr), .ram_data_rd(ram_data_rd)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] ram [N];
  always @(posedge clk) begin
    if (ram_en && ram_wr_rdn) ram[ram_addr] <= ram_data_wr;
    if (ram_en && !ram_wr_rdn) ram_data_rd <= ram[ram_addr];
  end
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d; logic l;} wr_t;
  typedef struct {logic [DW-1:0] d; logic l;} rd_t;
  wr_t exp_wr[$];
  rd_t exp_rd[$];
  logic [AW-1:0] exp_ra[$];
  logic [DW-1:0] ref_mem [N];
  int total = 0, passed = 0;
  int rr_mode = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", n, act, want);
  endtask
  task automatic fail(input string n);
    total++;
    $display("FAIL %s: event occurred or timed out, required otherwise", n);
  endtask
  initial begin
    rdata_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdata_ready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? ~rdata_ready :
                    rr_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end
  int outs;
  logic done_due, nd, iss, pp;
  wr_t we;
  rd_t re;
  initial begin
    outs = 0;
    done_due = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        outs = 0;
        done_due = 1'b0;
      end else begin
        if (done || done_due) chk("done_pulse", done, done_due);
        nd = 1'b0;
        if (ram_en && ram_wr_rdn) begin
          if (exp_wr.size() == 0) fail("unexpected_ram_write");
          else begin
            we = exp_wr.pop_front();
            chk("wr_addr", ram_addr, we.a);
            chk("wr_data", ram_data_wr, we.d);
            nd = we.l;
          end
        end
        iss = ram_en && !ram_wr_rdn;
        pp = rdata_valid && rdata_ready;
        if (iss) begin
          if (exp_ra.size() == 0) fail("unexpected_ram_read");
          else chk("rd_addr", ram_addr, exp_ra.pop_front());
        end
        outs = outs - int'(pp) + int'(iss);
        if (iss) chk("rd_occupancy_le2", outs <= 2, 1);
        if (pp) begin
          if (exp_rd.size() == 0) fail("unexpected_rdata");
          else begin
            re = exp_rd.pop_front();
            chk("rdata", rdata, re.d);
            chk("rdata_last", rdata_last, re.l);
            nd = re.l;
          end
        end
        done_due = nd;
      end
    end
  end
  task automatic reset_outputs_check();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_rdata_last", rdata_last, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_wr_rdn", ram_wr_rdn, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data_wr", ram_data_wr, 0);
    chk("rst_rdata", rdata, 0);
  endtask
  task automatic start_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] len);
    int c = 0;
    cmd_valid = 1'b1;
    cmd_wr = wr;
    cmd_addr = a;
    cmd_len = len;
    while (!cmd_ready && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (!cmd_ready) fail("cmd_accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask
  task automatic push_write(input logic [AW-1:0] a, input logic [AW-1:0] len,
                            input logic [DW-1:0] base, input bit rnd, output logic [DW-1:0] d[$]);
    logic [DW-1:0] v;
    logic [AW-1:0] ad;
    d = {};
    for (int i = 0; i <= int'(len); i++) begin
      v = rnd ? DW'($urandom) : base + DW'(i);
      ad = a + AW'(i);
      d.push_back(v);
      exp_wr.push_back('{ad, v, i == int'(len)});
      ref_mem[ad] = v;
    end
  endtask
  task automatic send_beats(input logic [DW-1:0] d[$], input int gap);
    int c;
    for (int i = 0; i < d.size(); i++) begin
      if (i > 0 && gap != 0) begin
        wdata_valid = 1'b0;
        repeat (gap == 1 ? 1 : $urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      wdata_valid = 1'b1;
      wdata = d[i];
      c = 0;
      while (!wdata_ready && c < 50) begin
        @(posedge clk);
        #1;
        c++;
      end
      if (!wdata_ready) fail("wdata_ready_timeout");
      @(posedge clk);
      #1;
    end
    wdata_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic write_burst(input logic [AW-1:0] a, input logic [AW-1:0] len,
                             input logic [DW-1:0] base, input bit rnd, input int gap);
    logic [DW-1:0] d[$];
    push_write(a, len, base, rnd, d);
    start_cmd(1'b1, a, len);
    send_beats(d, gap);
    if (exp_wr.size() != 0) fail("write_beats_left");
  endtask
  task automatic push_read(input logic [AW-1:0] a, input logic [AW-1:0] len);
    logic [AW-1:0] ad;
    for (int i = 0; i <= int'(len); i++) begin
      ad = a + AW'(i);
      exp_ra.push_back(ad);
      exp_rd.push_back('{ref_mem[ad], i == int'(len)});
    end
  endtask
  task automatic wait_read();
    int c = 0;
    while (exp_rd.size() != 0 && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (exp_rd.size() != 0) fail("read_timeout");
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask
  task automatic read_burst(input logic [AW-1:0] a, input logic [AW-1:0] len, input int mode);
    rr_mode = mode;
    push_read(a, len);
    start_cmd(1'b0, a, len);
    wait_read();
  endtask
  logic [DW-1:0] dq[$];
  logic [AW-1:0] ra, rl;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_outputs_check();
    rstn = 1'b1;
    @(posedge clk);
    #1;
    // 1: write with one-cycle gaps between beats
    write_burst(10'h010, 10'd3, 32'hA0, 1'b0, 1);
    // 2: read back at full rate, with exact first-beat timing
    rr_mode = 0;
    push_read(10'h010, 10'd3);
    start_cmd(1'b0, 10'h010, 10'd3);
    chk("t2_valid_accept", rdata_valid, 0);
    @(posedge clk);
    #1;
    chk("t2_valid_accept+1", rdata_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("t2_valid_streaming", rdata_valid, 1);
      chk("t2_last_position", rdata_last, k == 3);
    end
    wait_read();
    // 3: alternating backpressure, with stray wdata_valid during the read
    write_burst(10'h200, 10'd7, '0, 1'b1, 0);
    wdata_valid = 1'b1;
    read_burst(10'h200, 10'd7, 1);
    wdata_valid = 1'b0;
    // 4: address wrap
    write_burst(10'h3FE, 10'd3, 32'h5000, 1'b0, 2);
    read_burst(10'h3FE, 10'd3, 2);
    // 5: single-beat write with a read command held while busy
    push_write(10'h020, 10'd0, '0, 1'b1, dq);
    start_cmd(1'b1, 10'h020, 10'd0);
    cmd_valid = 1'b1;
    cmd_wr = 1'b0;
    push_read(10'h020, 10'd0);
    chk("t5_cmd_ready_busy", cmd_ready, 0);
    chk("t5_busy", busy, 1);
    wdata_valid = 1'b1;
    wdata = dq[0];
    @(posedge clk);
    #1;
    wdata_valid = 1'b0;
    chk("t5_cmd_ready_after", cmd_ready, 1);
    chk("t5_read_not_started", busy, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("t5_read_accepted", busy, 1);
    rr_mode = 0;
    wait_read();
    // 6: reset in the middle of a stalled read
    write_burst(10'h100, 10'd15, '0, 1'b1, 0);
    rr_mode = 3;
    push_read(10'h100, 10'd15);
    start_cmd(1'b0, 10'h100, 10'd15);
    repeat (8) @(posedge clk);
    #1;
    rstn = 1'b0;
    exp_rd = {};
    exp_ra = {};
    exp_wr = {};
    #1;
    reset_outputs_check();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    read_burst(10'h100, 10'd15, 0);
    // random traffic
    for (int n = 0; n < 20; n++) begin
      ra = AW'($urandom_range(0, N - 1));
      rl = AW'($urandom_range(0, 15));
      write_burst(ra, rl, '0, 1'b1, 2);
      read_burst(ra, rl, 2);
    end
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
